// File: rtl/prog_loader.sv
// Boot-time program loader: unpacks a framed byte stream (length, data, checksum)
// into instruction-memory words and holds the CPU in reset until the image checks out.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Kept 33 bits wide so the capacity compare stays exact against a full 32-bit length.
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_idx;
  logic [31:0]     n_words;
  logic [31:0]     asm_word;
  logic [7:0]      csum;

  logic        accept;
  logic [31:0] len_next;
  logic [31:0] word_next;

  // Valid/ready: a byte moves on a rising edge where in_valid && in_ready; in_valid
  // may drop at any time and only stalls the loader, which never accepts while rst is high.
  assign in_ready  = !rst && (state == S_LEN || state == S_DATA || state == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign len_next  = {in_data, n_words[31:8]};
  assign word_next = {in_data, asm_word[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LEN;
      byte_cnt  <= 2'd0;
      word_idx  <= '0;
      n_words   <= 32'd0;
      asm_word  <= 32'd0;
      csum      <= 8'd0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 32'd0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            n_words  <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if ({1'b0, len_next} > DEPTH) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else if (len_next == 32'd0) begin
                state <= S_CSUM;
              end else begin
                state    <= S_DATA;
                word_idx <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_word <= word_next;
            csum     <= csum + in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we   <= 1'b1;
              imem_addr <= word_idx[ADDR_W-1:0];
              imem_wd   <= word_next;
              word_idx  <= word_idx + 1'b1;
              if (32'(word_idx) + 32'd1 == n_words) begin
                state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state   <= S_RUN;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frame scenarios plus hand-written reset corner cases,
// with instruction-memory writes checked against an expected-write queue.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  two_word[2];

  typedef struct {
    int n;
    int gap_max;
    bit bad;
    bit exp_done;
    bit exp_err;
  } case_t;

  case_t cases[7];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  // clock / global time bound
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, imem_addr, imem_wd}, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("imem_write", {24'd0, imem_addr, imem_wd}, {24'd0, e});
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited;
    @(negedge clk);
    if (gap_max > 0) begin
      int gaps;
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    else @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int gap_max, input bit bad);
    logic [31:0] len;
    logic [31:0] w;
    logic [7:0]  cs;
    len = 32'(n);
    cs  = 8'd0;
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap_max);
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      w = (n == 2) ? two_word[i] : $urandom;
      for (int b = 0; b < 4; b++) begin
        cs = cs + w[8*b +: 8];
        if (b == 3) exp_q.push_back({ADDR_W'(i), w});
        send_byte(w[8*b +: 8], gap_max);
      end
    end
    send_byte(bad ? cs + 8'd1 : cs, gap_max);
  endtask

  task automatic send_partial(input int count);
    logic [7:0] bytes[8];
    bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00};
    for (int i = 0; i < count; i++) send_byte(bytes[i], 0);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rst_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_rst_we"}, 64'(imem_we), 64'd0);
    check({tag, "_rst_addr_wd"}, {24'd0, imem_addr, imem_wd}, 64'd0);
    check({tag, "_rst_flags"}, {61'd0, cpu_rst, done, err}, 64'b100);
    rst = 1'b0;
    #1;
    check({tag, "_len_ready"}, 64'(in_ready), 64'd1);
  endtask

  // called on the negedge right after the last accepted byte
  task automatic check_end(input string tag, input bit exp_done, input bit exp_err, input int n);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    if (n > 0 && n <= DEPTH) check({tag, "_addr_hold"}, 64'(imem_addr), 64'(n - 1));
    exp_q.delete();
    for (int k = 0; k < 3; k++) @(negedge clk);
    check({tag, "_sticky"}, {62'd0, done, err}, {62'd0, exp_done, exp_err});
  endtask

  initial begin
    two_word[0] = 32'h00500513;
    two_word[1] = 32'h00A00593;
    //           n    gap bad done err
    cases[0] = '{2,   0,  0,  1,   0};
    cases[1] = '{0,   0,  0,  1,   0};
    cases[2] = '{257, 0,  0,  0,   1};
    cases[3] = '{256, 0,  0,  1,   0};
    cases[4] = '{2,   0,  1,  0,   1};
    cases[5] = '{2,   3,  0,  1,   0};
    cases[6] = '{5,   2,  0,  1,   0};

    for (int c = 0; c < 7; c++) begin
      string tag;
      tag = $sformatf("case%0d", c);
      reset_dut(tag);
      send_frame(cases[c].n, cases[c].gap_max, cases[c].bad);
      @(negedge clk);
      in_valid = 1'b0;
      check_end(tag, cases[c].exp_done, cases[c].exp_err, cases[c].n);
    end

    // mid-load reset: 4 length bytes + 2 data bytes, then reset with junk on the bus
    reset_dut("midrst");
    send_partial(6);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_we_low", 64'(imem_we), 64'd0);
      check("midrst_not_ready", 64'(in_ready), 64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_flags", {61'd0, cpu_rst, done, err}, 64'b100);
    send_frame(2, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check_end("midrst_reload", 1'b1, 1'b0, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
